// File: rtl/biu_reg_bank_pkg.sv
// biu_reg_bank_pkg
// Shared definitions for the BIU register bank. It holds the register offsets,
// the field widths and the state encoding of the per-path accept FSM.
// There are no ports. biu_reg_bank and biu_reg_bank_fsm import this package.

package biu_reg_bank_pkg;

    // Only the low address byte is decoded.
    localparam int DEC_W      = 8;
    localparam int CTRL_W     = 8;
    localparam int STATUS_W   = 8;
    localparam int INTMASK_W  = 8;
    localparam int CYCLE_W    = 32;
    localparam int WAIT_CNT_W = 4;

    localparam logic [DEC_W-1:0] OFF_ID      = 8'h00;
    localparam logic [DEC_W-1:0] OFF_CTRL    = 8'h04;
    localparam logic [DEC_W-1:0] OFF_STATUS  = 8'h08;
    localparam logic [DEC_W-1:0] OFF_SCRATCH = 8'h0C;
    localparam logic [DEC_W-1:0] OFF_INTMASK = 8'h10;
    localparam logic [DEC_W-1:0] OFF_CYCLE   = 8'h14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_GAP  = 2'd3
    } acc_state_t;

endpackage

// File: rtl/biu_reg_bank_fsm.sv
// biu_reg_bank_fsm
// Accept sequencer for one BIU path, either read or write. It samples a request
// in IDLE, optionally waits LATENCY cycles and then pulses accept for one cycle.
// After that it spends one GAP cycle ignoring enable, so a request that is still
// held just after its accept is not serviced a second time.
//
//   state | meaning
//   IDLE  | waiting for enable; the request is sampled here
//   WAIT  | wait states; a down-counter counts to its terminal count of 0
//   ACK   | accept is high; the data path commits at the end of this cycle
//   GAP   | one cycle with enable ignored
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   enable     request from the BIU master
//   sample     high in IDLE when enable=1 (the address and data latch here)
//   enter_ack  high in the cycle before ACK (used to load the registered outputs)
//   accept     registered; high for exactly the ACK cycle

module biu_reg_bank_fsm
    import biu_reg_bank_pkg::*;
#(
    parameter int LATENCY = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic sample,
    output logic enter_ack,
    output logic accept
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        WAIT_CNT_W'((LATENCY > 0) ? (LATENCY - 1) : 0);

    acc_state_t            state;
    logic [WAIT_CNT_W-1:0] wait_cnt;

    assign sample    = (state == ST_IDLE) && enable;
    assign enter_ack = (LATENCY == 0) ? sample
                                      : ((state == ST_WAIT) && (wait_cnt == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            accept   <= 1'b0;
        end else begin
            accept <= enter_ack;
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        if (LATENCY == 0) begin
                            state <= ST_ACK;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= ST_ACK;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_ACK:  state <= ST_GAP;
                ST_GAP:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/biu_reg_bank.sv
// biu_reg_bank
// A small register bank behind a BIU with independent read and write paths.
//   0x00 ID (RO)   0x04 CTRL[7:0]   0x08 STATUS[7:0] (W1C, set by hw_set)
//   0x0C SCRATCH (byte-enabled)     0x10 INTMASK[7:0]
//   0x14 CYCLE (RO, free-running)   present only with BIU_REG_BANK_CYCLE_CNT_EN
// Any other offset and any misaligned address completes with error=1 and rdata=0.
//
// Ports:
//   clk, rst                               clock, asynchronous active-high reset
//   biu_waddr/wenable/wdata/wben           write request (held until accept)
//   biu_waccept, biu_werror                write done pulse, error qualified by it
//   biu_raddr/renable                      read request (held until accept)
//   biu_rdata, biu_raccept, biu_rerror     read data (valid only in accept), done, error
//   hw_set                                 per-bit STATUS set events
//   ctrl                                   CTRL register
//   irq                                    registered |(STATUS & INTMASK)

module biu_reg_bank
    import biu_reg_bank_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int          LATENCY    = 0,
    parameter logic [31:0] ID_VALUE   = 32'h5658_0001
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   biu_waddr,
    input  logic                    biu_wenable,
    input  logic [DATA_WIDTH-1:0]   biu_wdata,
    input  logic [DATA_WIDTH/8-1:0] biu_wben,
    output logic                    biu_waccept,
    output logic                    biu_werror,
    input  logic [ADDR_WIDTH-1:0]   biu_raddr,
    input  logic                    biu_renable,
    output logic [DATA_WIDTH-1:0]   biu_rdata,
    output logic                    biu_raccept,
    output logic                    biu_rerror,
    input  logic [7:0]              hw_set,
    output logic [7:0]              ctrl,
    output logic                    irq
);

    logic                    w_sample, w_enter_ack;
    logic                    r_sample, r_enter_ack;
    logic [DEC_W-1:0]        waddr_q, raddr_q, w_off, r_off;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wben_q;

    logic [CTRL_W-1:0]       ctrl_q;
    logic [STATUS_W-1:0]     status_q, st_clr;
    logic [INTMASK_W-1:0]    intmask_q;
    logic [DATA_WIDTH-1:0]   scratch_q;

    logic [DATA_WIDTH-1:0]   rd_val;
    logic                    rd_err, wr_err, wr_commit;
    logic                    unused_addr_hi;

`ifdef BIU_REG_BANK_CYCLE_CNT_EN
    logic [CYCLE_W-1:0]      cycle_q;
`endif

    assign unused_addr_hi = ^{biu_waddr[ADDR_WIDTH-1:DEC_W], biu_raddr[ADDR_WIDTH-1:DEC_W]};

    biu_reg_bank_fsm #(.LATENCY(LATENCY)) u_wr_fsm (
        .clk       (clk),
        .rst       (rst),
        .enable    (biu_wenable),
        .sample    (w_sample),
        .enter_ack (w_enter_ack),
        .accept    (biu_waccept)
    );

    biu_reg_bank_fsm #(.LATENCY(LATENCY)) u_rd_fsm (
        .clk       (clk),
        .rst       (rst),
        .enable    (biu_renable),
        .sample    (r_sample),
        .enter_ack (r_enter_ack),
        .accept    (biu_raccept)
    );

    // With LATENCY=0 the sample edge is also the edge that enters ACK. At that
    // point the latches do not hold the new request yet, so decode the live address.
    assign w_off = w_sample ? biu_waddr[DEC_W-1:0] : waddr_q;
    assign r_off = r_sample ? biu_raddr[DEC_W-1:0] : raddr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waddr_q <= '0;
            wdata_q <= '0;
            wben_q  <= '0;
            raddr_q <= '0;
        end else begin
            if (w_sample) begin
                waddr_q <= biu_waddr[DEC_W-1:0];
                wdata_q <= biu_wdata;
                wben_q  <= biu_wben;
            end
            if (r_sample) begin
                raddr_q <= biu_raddr[DEC_W-1:0];
            end
        end
    end

    always_comb begin
        rd_val = '0;
        rd_err = 1'b0;
        if (r_off[1:0] != 2'b00) begin
            rd_err = 1'b1;
        end else begin
            case (r_off)
                OFF_ID:      rd_val = DATA_WIDTH'(ID_VALUE);
                OFF_CTRL:    rd_val = DATA_WIDTH'(ctrl_q);
                OFF_STATUS:  rd_val = DATA_WIDTH'(status_q);
                OFF_SCRATCH: rd_val = scratch_q;
                OFF_INTMASK: rd_val = DATA_WIDTH'(intmask_q);
`ifdef BIU_REG_BANK_CYCLE_CNT_EN
                OFF_CYCLE:   rd_val = DATA_WIDTH'(cycle_q);
`endif
                default:     rd_err = 1'b1;
            endcase
        end
    end

    always_comb begin
        wr_err = 1'b0;
        if (w_off[1:0] != 2'b00) begin
            wr_err = 1'b1;
        end else begin
            case (w_off)
                OFF_CTRL, OFF_STATUS, OFF_SCRATCH, OFF_INTMASK: wr_err = 1'b0;
                OFF_ID, OFF_CYCLE:                              wr_err = 1'b1;
                default:                                        wr_err = 1'b1;
            endcase
        end
    end

    // Read data and errors are snapshotted on entry to ACK. The write commits at
    // the end of ACK, so a read that completes in the same cycle sees the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            biu_rdata  <= '0;
            biu_rerror <= 1'b0;
            biu_werror <= 1'b0;
        end else begin
            biu_rdata  <= r_enter_ack ? rd_val : '0;
            biu_rerror <= r_enter_ack & rd_err;
            biu_werror <= w_enter_ack & wr_err;
        end
    end

    assign wr_commit = biu_waccept & ~biu_werror;

    always_comb begin
        st_clr = '0;
        if (wr_commit && (waddr_q == OFF_STATUS) && wben_q[0]) begin
            st_clr = wdata_q[STATUS_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q    <= '0;
            status_q  <= '0;
            intmask_q <= '0;
            scratch_q <= '0;
            irq       <= 1'b0;
        end else begin
            // A set wins over a simultaneous clear of the same bit.
            status_q <= (status_q & ~st_clr) | hw_set;
            irq      <= |(status_q & intmask_q);
            if (wr_commit && (waddr_q == OFF_CTRL) && wben_q[0]) begin
                ctrl_q <= wdata_q[CTRL_W-1:0];
            end
            if (wr_commit && (waddr_q == OFF_INTMASK) && wben_q[0]) begin
                intmask_q <= wdata_q[INTMASK_W-1:0];
            end
            if (wr_commit && (waddr_q == OFF_SCRATCH)) begin
                for (int b = 0; b < DATA_WIDTH/8; b++) begin
                    if (wben_q[b]) begin
                        scratch_q[8*b +: 8] <= wdata_q[8*b +: 8];
                    end
                end
            end
        end
    end

`ifdef BIU_REG_BANK_CYCLE_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 1'b1;
        end
    end
`endif

    assign ctrl = ctrl_q;

endmodule

// File: tb/tb_biu_reg_bank.sv
`timescale 1ns/1ps
module tb_biu_reg_bank;

    localparam int          LAT0 = 0;
    localparam int          LAT1 = 3;
    localparam logic [31:0] IDV  = 32'h5658_0001;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0 runs with LATENCY=0 and instance 1 with LATENCY=3.
    logic        rst[2];
    logic [31:0] waddr[2], raddr[2], wdata[2], rdata[2];
    logic        wen[2], ren[2], wacc[2], werr[2], racc[2], rerr[2], irq[2];
    logic [3:0]  wben[2];
    logic [7:0]  hw[2], ctrl[2];

    biu_reg_bank #(.LATENCY(LAT0)) u_l0 (
        .clk(clk), .rst(rst[0]),
        .biu_waddr(waddr[0]), .biu_wenable(wen[0]), .biu_wdata(wdata[0]), .biu_wben(wben[0]),
        .biu_waccept(wacc[0]), .biu_werror(werr[0]),
        .biu_raddr(raddr[0]), .biu_renable(ren[0]),
        .biu_rdata(rdata[0]), .biu_raccept(racc[0]), .biu_rerror(rerr[0]),
        .hw_set(hw[0]), .ctrl(ctrl[0]), .irq(irq[0])
    );

    biu_reg_bank #(.LATENCY(LAT1)) u_l3 (
        .clk(clk), .rst(rst[1]),
        .biu_waddr(waddr[1]), .biu_wenable(wen[1]), .biu_wdata(wdata[1]), .biu_wben(wben[1]),
        .biu_waccept(wacc[1]), .biu_werror(werr[1]),
        .biu_raddr(raddr[1]), .biu_renable(ren[1]),
        .biu_rdata(rdata[1]), .biu_raccept(racc[1]), .biu_rerror(rerr[1]),
        .hw_set(hw[1]), .ctrl(ctrl[1]), .irq(irq[1])
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural reference model: one register image per instance.
    logic [7:0]  m_ctrl[2], m_status[2], m_intmask[2];
    logic [31:0] m_scratch[2];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int lat(int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    function automatic void m_reset(int d);
        m_ctrl[d] = 8'h00; m_status[d] = 8'h00; m_intmask[d] = 8'h00; m_scratch[d] = 32'h0;
    endfunction

    // The result is {error, data}.
    function automatic logic [32:0] m_read(int d, logic [31:0] a);
        logic [7:0] o;
        o = a[7:0];
        if (o[1:0] != 2'b00) return {1'b1, 32'h0};
        case (o)
            8'h00:   return {1'b0, IDV};
            8'h04:   return {1'b0, 24'h0, m_ctrl[d]};
            8'h08:   return {1'b0, 24'h0, m_status[d]};
            8'h0C:   return {1'b0, m_scratch[d]};
            8'h10:   return {1'b0, 24'h0, m_intmask[d]};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    // Applies a write to the model image and returns the expected error flag.
    function automatic logic m_write(int d, logic [31:0] a, logic [31:0] v, logic [3:0] be);
        logic [7:0] o;
        o = a[7:0];
        if (o[1:0] != 2'b00) return 1'b1;
        case (o)
            8'h04: begin if (be[0]) m_ctrl[d] = v[7:0]; return 1'b0; end
            8'h08: begin if (be[0]) m_status[d] = m_status[d] & ~v[7:0]; return 1'b0; end
            8'h0C: begin
                for (int b = 0; b < 4; b++) if (be[b]) m_scratch[d][8*b +: 8] = v[8*b +: 8];
                return 1'b0;
            end
            8'h10: begin if (be[0]) m_intmask[d] = v[7:0]; return 1'b0; end
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [7:0] pick_off();
        int          k;
        logic [31:0] r;
        k = $urandom_range(0, 8);
        r = $urandom;
        case (k)
            0: return 8'h00;
            1: return 8'h04;
            2: return 8'h08;
            3: return 8'h0C;
            4: return 8'h10;
`ifdef BIU_REG_BANK_CYCLE_CNT_EN
            5: return 8'h18;
`else
            5: return 8'h14;
`endif
            6: return 8'h20;
            7: return {r[7:2], 2'b10};
            default: return 8'hFC;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(int d, logic [31:0] a, logic [31:0] exp_d, logic exp_e,
                           bit chk_data, string tag, output logic [31:0] got_d);
        int n;
        bit got;
        n = 0; got = 0; got_d = 32'h0;
        raddr[d] = a; ren[d] = 1'b1;
        while (!got && n < 40) begin
            tick();
            n++;
            if (racc[d]) got = 1;
            else if (n == 1) raddr[d] = $urandom;  // must not matter once sampled
        end
        got_d = rdata[d];
        check({tag, " racc"}, 32'(got), 32'd1);
        check({tag, " rlat"}, 32'(n), 32'(lat(d) + 1));
        if (chk_data) check({tag, " rdata"}, rdata[d], exp_d);
        check({tag, " rerr"}, 32'(rerr[d]), 32'(exp_e));
        ren[d] = 1'b0;
        tick();
        check({tag, " rpulse"}, 32'(racc[d]), 32'd0);
        check({tag, " rdata_idle"}, rdata[d], 32'h0);
        tick();
    endtask

    task automatic do_write(int d, logic [31:0] a, logic [31:0] v, logic [3:0] be,
                            logic exp_e, string tag);
        int n;
        bit got;
        n = 0; got = 0;
        waddr[d] = a; wdata[d] = v; wben[d] = be; wen[d] = 1'b1;
        while (!got && n < 40) begin
            tick();
            n++;
            if (wacc[d]) got = 1;
            else if (n == 1) begin
                waddr[d] = $urandom; wdata[d] = $urandom; wben[d] = 4'($urandom);
            end
        end
        check({tag, " wacc"}, 32'(got), 32'd1);
        check({tag, " wlat"}, 32'(n), 32'(lat(d) + 1));
        check({tag, " werr"}, 32'(werr[d]), 32'(exp_e));
        wen[d] = 1'b0;
        tick();
        check({tag, " wpulse"}, 32'(wacc[d]), 32'd0);
        tick();
    endtask

    task automatic rd_model(int d, logic [31:0] a, string tag);
        logic [32:0] e;
        logic [31:0] dummy;
        e = m_read(d, a);
        do_read(d, a, e[31:0], e[32], 1'b1, tag, dummy);
    endtask

    task automatic wr_model(int d, logic [31:0] a, logic [31:0] v, logic [3:0] be, string tag);
        logic e;
        e = m_write(d, a, v, be);
        do_write(d, a, v, be, e, tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] e;
        logic [31:0] v, v1, v2, dummy;
        logic        er;
        int          acc, since, d, nidle;
        logic [7:0]  h;

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; waddr[i] = '0; raddr[i] = '0; wdata[i] = '0; wben[i] = '0;
            wen[i] = 1'b0; ren[i] = 1'b0; hw[i] = '0;
            m_reset(i);
        end
        tick(); tick();
        for (int i = 0; i < 2; i++) begin
            check("rst ctrl", 32'(ctrl[i]), 32'h0);
            check("rst irq", 32'(irq[i]), 32'h0);
            check("rst acc", {30'h0, wacc[i], racc[i]}, 32'h0);
            check("rst err", {30'h0, werr[i], rerr[i]}, 32'h0);
            check("rst rdata", rdata[i], 32'h0);
        end
        rst[0] = 1'b0; rst[1] = 1'b0;
        tick();

        // ID reads at both latencies
        rd_model(0, 32'h00, "id_l0");
        rd_model(1, 32'h00, "id_l3");

        // byte-enabled SCRATCH write with LATENCY=3
        wr_model(1, 32'h0C, 32'hF1F2_F3F4, 4'b0101, "scr_w");
        rd_model(1, 32'h0C, "scr_r");
        check("scr_model", m_scratch[1], 32'h00F2_00F4);

        // errors and the write with no byte enables
        wr_model(0, 32'h0C, 32'hA5A5_5A5A, 4'hF, "scr0_w");
        rd_model(0, 32'h20, "err_rd20");
        wr_model(0, 32'h02, 32'hFFFF_FFFF, 4'hF, "err_wr02");
        wr_model(0, 32'h00, 32'h1234_5678, 4'hF, "err_wr_id");
        rd_model(0, 32'h0C, "err_scr_keep");
        wr_model(0, 32'h04, 32'h0000_00C3, 4'h1, "ctrl_w");
        wr_model(0, 32'h04, 32'h0000_0011, 4'h0, "ctrl_wben0");
        check("ctrl_port", 32'(ctrl[0]), 32'(m_ctrl[0]));

        // the interrupt path
        wr_model(0, 32'h10, 32'h01, 4'h1, "imask_w");
        check("irq_pre", 32'(irq[0]), 32'd0);
        hw[0] = 8'h01;
        tick();
        hw[0] = 8'h00;
        m_status[0] = m_status[0] | 8'h01;
        check("irq_lag", 32'(irq[0]), 32'd0);
        tick();
        check("irq_set", 32'(irq[0]), 32'd1);
        hw[0] = 8'h01;
        wr_model(0, 32'h08, 32'h01, 4'h1, "w1c_race");
        m_status[0] = m_status[0] | 8'h01;
        hw[0] = 8'h00;
        rd_model(0, 32'h08, "w1c_race_rd");
        check("irq_race", 32'(irq[0]), 32'd1);
        wr_model(0, 32'h08, 32'h01, 4'h1, "w1c_clr");
        check("irq_clr", 32'(irq[0]), 32'd0);
        rd_model(0, 32'h08, "w1c_clr_rd");

        // a read and a write completing in the same cycle
        v = $urandom;
        e = m_read(0, 32'h0C);
        er = m_write(0, 32'h0C, v, 4'hF);
        fork
            do_write(0, 32'h0C, v, 4'hF, er, "same_w");
            do_read(0, 32'h0C, e[31:0], e[32], 1'b1, "same_r", dummy);
        join
        rd_model(0, 32'h0C, "same_after");

        // enable held two cycles past accept
        er = m_write(0, 32'h04, 32'h5A, 4'h1);
        waddr[0] = 32'h04; wdata[0] = 32'h5A; wben[0] = 4'h1; wen[0] = 1'b1;
        acc = 0; since = -1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (wacc[0]) begin acc++; since = 0; end
            else if (since >= 0) since++;
            if (since == 2) wen[0] = 1'b0;
        end
        wen[0] = 1'b0;
        check("hold_one_acc", 32'(acc), 32'd1);
        check("hold_ctrl", 32'(ctrl[0]), 32'(m_ctrl[0]));

        // reset while a write is waiting in WAIT
        wr_model(1, 32'h04, 32'h77, 4'h1, "pre_rst_ctrl");
        waddr[1] = 32'h0C; wdata[1] = 32'hDEAD_BEEF; wben[1] = 4'hF; wen[1] = 1'b1;
        tick(); tick();
        wen[1] = 1'b0;
        #2 rst[1] = 1'b1;
        #2 rst[1] = 1'b0;
        m_reset(1);
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (wacc[1]) acc++;
        end
        check("rst_wait_noacc", 32'(acc), 32'd0);
        check("rst_wait_ctrl", 32'(ctrl[1]), 32'h0);
        rd_model(1, 32'h0C, "rst_wait_scr");

        // CYCLE register
`ifdef BIU_REG_BANK_CYCLE_CNT_EN
        nidle = $urandom_range(2, 20);
        do_read(0, 32'h14, 32'h0, 1'b0, 1'b0, "cyc_a", v1);
        for (int i = 0; i < nidle; i++) tick();
        do_read(0, 32'h14, 32'h0, 1'b0, 1'b0, "cyc_b", v2);
        // The sample edges are nidle + 3 apart: 3 edges per read plus the idle ticks.
        check("cyc_delta", v2 - v1, 32'(nidle + 3));
        wr_model(0, 32'h14, 32'h0, 4'hF, "cyc_wr");
`else
        nidle = 0;
        rd_model(0, 32'h14, "cyc_unmapped_rd");
        wr_model(0, 32'h14, 32'h0, 4'hF, "cyc_unmapped_wr");
`endif

        // randomized traffic against the model
        for (int it = 0; it < 60; it++) begin
            d = $urandom_range(0, 1);
            v = {24'h0, pick_off()};
            if ($urandom_range(0, 1) == 1) begin
                wr_model(d, v, $urandom, 4'($urandom_range(0, 15)), "rnd_w");
            end else begin
                rd_model(d, v, "rnd_r");
            end
            if ($urandom_range(0, 5) == 0) begin
                h = 8'($urandom);
                hw[d] = h;
                tick();
                hw[d] = 8'h00;
                m_status[d] = m_status[d] | h;
                tick();
            end
            for (int i = 0; i < 2; i++) begin
                check("rnd_irq", 32'(irq[i]), 32'(|(m_status[i] & m_intmask[i])));
                check("rnd_ctrl", 32'(ctrl[i]), 32'(m_ctrl[i]));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
